instr_decode_queue: RTL and testbench

- Parametrised instruction buffer between fetch and decode in the pipelined MIPS core.
- Accepts fetched instruction words with their PC and a fetch-exception flag through a valid/ready handshake.
- Stores them in a circular queue of DEPTH entries and presents the head entry to decode already split into MIPS fields.
- Supports a synchronous flush for branch/exception redirect. A fetched word flagged as faulting is stored as a nop.

---
 rtl/instr_decode_queue.sv | 97 +++++++++
 tb/tb_instr_decode_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer with a valid/ready
// handshake on each side, presenting the head entry split into MIPS fields.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_exc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shift,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_C = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);

  logic [31:0]      instr_q [DEPTH];
  logic [PC_W-1:0]  pc_q    [DEPTH];
  logic [DEPTH-1:0] exc_q;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic             pop;
  logic [31:0]      head_word;

  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      exc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        // faulting fetches become sll nop so decode sees nothing harmful
        instr_q[tail] <= in_exc ? 32'h0 : in_instr;
        pc_q[tail]    <= in_pc;
        exc_q[tail]   <= in_exc;
        tail          <= tail + ONE_P;
      end
      if (pop)
        head <= head + ONE_P;
      if (push && !pop)
        cnt <= cnt + ONE_C;
      else if (pop && !push)
        cnt <= cnt - ONE_C;
    end
  end

  // empty queue reads zero regardless of stale storage
  assign head_word = out_valid ? instr_q[head] : 32'h0;
  assign out_pc    = out_valid ? pc_q[head] : '0;
  assign out_exc   = out_valid & exc_q[head];

  assign opcode = head_word[31:26];
  assign rs     = head_word[25:21];
  assign rt     = head_word[20:16];
  assign rd     = head_word[15:11];
  assign shift  = head_word[10:6];
  assign funct  = head_word[5:0];
  assign imm16  = head_word[15:0];
  assign imm26  = head_word[25:0];

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue.
module tb_instr_decode_queue;

  logic        clk = 0;
  logic        reset = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_instr = 0;
  logic [31:0] in_pc = 0;
  logic        in_exc = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_pc;
  logic        out_exc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shift;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_decode_queue #(.DEPTH(4), .PTR_W(2), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_exc(out_exc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shift(shift), .funct(funct),
    .imm16(imm16), .imm26(imm26), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; flush = 0; in_exc = 0;
    reset = 0;
    step();
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] hw;
    reset = 0;
    step();
    step();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold count=%0d ov=%b ir=%b want 0 0 1",
               count, out_valid, in_ready);
    end
    reset = 1;
    step();
    hw = {opcode, imm26};
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 ||
        opcode !== 6'd0 || imm26 !== 26'd0 || out_pc !== 32'd0 ||
        out_exc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ov=%b ir=%b cnt=%0d word=%h pc=%h exc=%b want 0 1 0 0 0 0",
               out_valid, in_ready, count, hw, out_pc, out_exc);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    in_valid = 1; in_instr = 32'h8D09_0004; in_pc = 32'h3000; out_ready = 0;
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || opcode !== 6'h23 || rs !== 5'd8 ||
        rt !== 5'd9 || imm16 !== 16'h0004 || out_pc !== 32'h3000 ||
        count !== 3'd1 || rd !== 5'd0 || funct !== 6'h04) begin
      errors++;
      $display("FAIL single_push ov=%b op=%h rs=%0d rt=%0d imm=%h pc=%h cnt=%0d want 1 23 8 9 0004 3000 1",
               out_valid, opcode, rs, rt, imm16, out_pc, count);
    end
  endtask

  task automatic test_fill_refuse();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_instr = 32'h11 + i; in_pc = 32'h100 + 4*i;
      step();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || imm26 !== 26'h11) begin
      errors++;
      $display("FAIL fill count=%0d ir=%b head=%h want 4 0 11",
               count, in_ready, imm26);
    end
    in_instr = 32'h15; out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if (count !== 3'd3 || imm26 !== 26'h12 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL refuse count=%0d head=%h ir=%b want 3 12 1",
               count, imm26, in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || imm26 !== 26'h12) begin
      errors++;
      $display("FAIL refill count=%0d ir=%b head=%h want 4 0 12",
               count, in_ready, imm26);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imm26 !== 26'h12 + 26'(i)) begin
        errors++;
        $display("FAIL drain_%0d head=%h want %h", i, imm26, 26'h12 + 26'(i));
      end
      step();
    end
    out_ready = 0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty count=%0d ov=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_stream_wrap();
    do_reset();
    in_valid = 1; out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      in_instr = 32'(i); in_pc = 32'(4*i);
      step();
      checks++;
      if ({opcode, imm26} !== 32'(i) || count !== 3'd1 ||
          out_pc !== 32'(4*i)) begin
        errors++;
        $display("FAIL stream_%0d head=%h cnt=%0d pc=%h want %h 1 %h",
                 i, {opcode, imm26}, count, out_pc, i, 4*i);
      end
    end
    in_valid = 0;
    step();
    out_ready = 0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end count=%0d ov=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_exception();
    do_reset();
    in_valid = 1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h3001; in_exc = 1;
    step();
    in_instr = 32'h0109_5025; in_pc = 32'h3004; in_exc = 0;
    step();
    in_valid = 0;
    checks++;
    if (opcode !== 6'd0 || funct !== 6'd0 || rs !== 5'd0 ||
        out_exc !== 1'b1 || out_pc !== 32'h3001 || count !== 3'd2) begin
      errors++;
      $display("FAIL exc_head op=%h fn=%h rs=%0d exc=%b pc=%h cnt=%0d want 0 0 0 1 3001 2",
               opcode, funct, rs, out_exc, out_pc, count);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if (out_exc !== 1'b0 || funct !== 6'h25 || rd !== 5'd10 ||
        out_pc !== 32'h3004 || count !== 3'd1) begin
      errors++;
      $display("FAIL exc_next exc=%b fn=%h rd=%0d pc=%h cnt=%0d want 0 25 10 3004 1",
               out_exc, funct, rd, out_pc, count);
    end
  endtask

  task automatic test_flush_async_reset();
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_instr = 32'hA0 + i; in_pc = 32'h200 + 4*i;
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre count=%0d want 3", count);
    end
    flush = 1; in_instr = 32'hBB; out_ready = 1;
    step();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_pc !== 32'd0 || imm26 !== 26'd0) begin
      errors++;
      $display("FAIL flush count=%0d ov=%b ir=%b pc=%h imm=%h want 0 0 1 0 0",
               count, out_valid, in_ready, out_pc, imm26);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_instr = 32'hC0 + i; in_pc = 32'h300 + 4*i;
      step();
    end
    in_valid = 0;
    checks++;
    if (count !== 3'd2 || imm26 !== 26'hC0) begin
      errors++;
      $display("FAIL refill count=%0d head=%h want 2 c0", count, imm26);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset count=%0d ov=%b ir=%b want 0 0 1",
               count, out_valid, in_ready);
    end
    step();
    reset = 1;
    step();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || opcode !== 6'd0) begin
      errors++;
      $display("FAIL post_reset count=%0d ov=%b op=%h want 0 0 0",
               count, out_valid, opcode);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_refuse();
    test_stream_wrap();
    test_exception();
    test_flush_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
